// File: rtl/ex_result_buffer_if.sv
// Handshake bundle between the ALU stage, the result buffer and the memory/writeback stage.
// The buffer itself connects through the slave modport.
interface ex_result_buffer_if #(
    parameter int WORDSIZE = 64
);
    logic                in_valid;
    logic                in_ready;
    logic [WORDSIZE-1:0] in_result;
    logic [3:0]          in_flags;
    logic [2:0]          in_funct3;
    logic [4:0]          in_rd;
    logic                in_is_branch;
    logic [WORDSIZE-1:0] in_target;
    logic                flush;
    logic                out_valid;
    logic                out_ready;
    logic [WORDSIZE-1:0] out_result;
    logic [4:0]          out_rd;
    logic                out_overflow;
    logic                redirect_valid;
    logic [WORDSIZE-1:0] redirect_target;
    logic                illegal_branch;

    modport master (
        output in_valid, in_result, in_flags, in_funct3, in_rd, in_is_branch, in_target,
        output flush, out_ready,
        input  in_ready, out_valid, out_result, out_rd, out_overflow,
        input  redirect_valid, redirect_target, illegal_branch
    );

    modport slave (
        input  in_valid, in_result, in_flags, in_funct3, in_rd, in_is_branch, in_target,
        input  flush, out_ready,
        output in_ready, out_valid, out_result, out_rd, out_overflow,
        output redirect_valid, redirect_target, illegal_branch
    );
endinterface

// File: rtl/ex_result_buffer.sv
// Two-entry skid buffer after the ALU: holds results in FIFO order and resolves
// conditional branches at push time, pulsing a redirect to fetch one cycle later.
module ex_result_buffer #(
    parameter int WORDSIZE = 64,
    parameter int DEPTH    = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    ex_result_buffer_if.slave bus
);
    localparam logic [1:0] FULL_COUNT = 2'(DEPTH);

    logic [1:0]          count_r;
    logic                wr_ptr_r;
    logic                rd_ptr_r;
    logic [WORDSIZE-1:0] res_mem_r [2];
    logic [4:0]          rd_mem_r  [2];
    logic [1:0]          ovf_mem_r;
    logic                redirect_valid_r;
    logic [WORDSIZE-1:0] redirect_target_r;
    logic                illegal_branch_r;

    logic in_ready_s;
    logic out_valid_s;
    logic push_s;
    logic pop_s;
    logic taken_s;
    logic illegal_s;

    assign in_ready_s  = (count_r < FULL_COUNT);
    assign out_valid_s = (count_r != 2'd0);
    // Flush overrides both sides of the handshake for the edge it is sampled on.
    assign push_s      = bus.in_valid && in_ready_s && !bus.flush;
    assign pop_s       = out_valid_s && bus.out_ready && !bus.flush;

    // Branch condition decode from ALU flags: [3]=eq, [2]=slt, [1]=ult.
    always_comb begin
        taken_s   = 1'b0;
        illegal_s = 1'b0;
        case (bus.in_funct3)
            3'b000:  taken_s = bus.in_flags[3];
            3'b001:  taken_s = !bus.in_flags[3];
            3'b100:  taken_s = bus.in_flags[2];
            3'b101:  taken_s = !bus.in_flags[2];
            3'b110:  taken_s = bus.in_flags[1];
            3'b111:  taken_s = !bus.in_flags[1];
            default: illegal_s = 1'b1;
        endcase
    end

    // Occupancy and read/write pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r  <= 2'd0;
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
        end else if (bus.flush) begin
            count_r  <= 2'd0;
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= ~wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + 2'd1;
                2'b01:   count_r <= count_r - 2'd1;
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; branch entries are stored with rd=0 so they never write back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                res_mem_r[i] <= '0;
                rd_mem_r[i]  <= 5'd0;
            end
            ovf_mem_r <= 2'b00;
        end else if (push_s) begin
            res_mem_r[wr_ptr_r] <= bus.in_result;
            rd_mem_r[wr_ptr_r]  <= bus.in_is_branch ? 5'd0 : bus.in_rd;
            ovf_mem_r[wr_ptr_r] <= bus.in_flags[0];
        end
    end

    // One-cycle redirect / illegal pulses for branches accepted on this edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_valid_r  <= 1'b0;
            redirect_target_r <= '0;
            illegal_branch_r  <= 1'b0;
        end else begin
            redirect_valid_r  <= push_s && bus.in_is_branch && taken_s;
            redirect_target_r <= (push_s && bus.in_is_branch && taken_s) ? bus.in_target : '0;
            illegal_branch_r  <= push_s && bus.in_is_branch && illegal_s;
        end
    end

    assign bus.in_ready        = in_ready_s;
    assign bus.out_valid       = out_valid_s;
    assign bus.out_result      = out_valid_s ? res_mem_r[rd_ptr_r] : '0;
    assign bus.out_rd          = out_valid_s ? rd_mem_r[rd_ptr_r] : 5'd0;
    assign bus.out_overflow    = out_valid_s ? ovf_mem_r[rd_ptr_r] : 1'b0;
    assign bus.redirect_valid  = redirect_valid_r;
    assign bus.redirect_target = redirect_target_r;
    assign bus.illegal_branch  = illegal_branch_r;
endmodule
